// File: rtl/vga_timing_ctrl.sv
// 640x480@60 VGA timing: free-running h/v counters, combinational pixel coordinate
// out to the pixel generators, and one register stage aligning colour with sync.
module vga_timing_ctrl #(
    parameter int H_SYNC   = 96,
    parameter int H_BACK   = 48,
    parameter int H_ACTIVE = 640,
    parameter int H_FRONT  = 16,
    parameter int V_SYNC   = 2,
    parameter int V_BACK   = 33,
    parameter int V_ACTIVE = 480,
    parameter int V_FRONT  = 10,
    parameter int SYNC_POL = 0
) (
    input  logic        vga_clk,
    input  logic        rst_n,
    input  logic [23:0] pos_data,
    output logic [9:0]  pos_x,
    output logic [9:0]  pos_y,
    output logic        hsync,
    output logic        vsync,
    output logic [11:0] rgb,
    output logic        data_en,
    output logic        frame_start
);

    localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
    localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;

    localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_SYNCW = 10'(H_SYNC);
    localparam logic [9:0] V_SYNCW = 10'(V_SYNC);
    localparam logic [9:0] H_ACT_S = 10'(H_SYNC + H_BACK);
    localparam logic [9:0] H_ACT_E = 10'(H_SYNC + H_BACK + H_ACTIVE);
    localparam logic [9:0] V_ACT_S = 10'(V_SYNC + V_BACK);
    localparam logic [9:0] V_ACT_E = 10'(V_SYNC + V_BACK + V_ACTIVE);
    localparam logic       SYNC_ON = 1'(SYNC_POL);

    logic [9:0]  h_cnt_q, h_cnt_d;
    logic [9:0]  v_cnt_q, v_cnt_d;
    logic        hsync_q, hsync_d;
    logic        vsync_q, vsync_d;
    logic [11:0] rgb_q, rgb_d;
    logic        data_en_q, data_en_d;
    logic        frame_start_q, frame_start_d;

    logic h_wrap, h_act, v_act, act;

    // Only the top nibble of each colour channel reaches the 4-bit DAC.
    logic unused_pos_data;
    assign unused_pos_data = ^{pos_data[19:16], pos_data[11:8], pos_data[3:0]};

    always_comb begin
        h_wrap  = (h_cnt_q == H_LAST);
        h_cnt_d = h_wrap ? 10'd0 : h_cnt_q + 10'd1;
        v_cnt_d = v_cnt_q;
        if (h_wrap) begin
            v_cnt_d = (v_cnt_q == V_LAST) ? 10'd0 : v_cnt_q + 10'd1;
        end
    end

    always_comb begin
        h_act = (h_cnt_q >= H_ACT_S) && (h_cnt_q < H_ACT_E);
        v_act = (v_cnt_q >= V_ACT_S) && (v_cnt_q < V_ACT_E);
        act   = h_act && v_act;
        pos_x = act ? h_cnt_q - H_ACT_S : 10'd0;
        pos_y = act ? v_cnt_q - V_ACT_S : 10'd0;
    end

    always_comb begin
        hsync_d       = (h_cnt_q < H_SYNCW) ? SYNC_ON : ~SYNC_ON;
        vsync_d       = (v_cnt_q < V_SYNCW) ? SYNC_ON : ~SYNC_ON;
        data_en_d     = act;
        rgb_d         = act ? {pos_data[23:20], pos_data[15:12], pos_data[7:4]} : 12'h000;
        frame_start_d = (h_cnt_q == 10'd0) && (v_cnt_q == 10'd0);
    end

    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt_q       <= 10'd0;
            v_cnt_q       <= 10'd0;
            hsync_q       <= ~SYNC_ON;
            vsync_q       <= ~SYNC_ON;
            rgb_q         <= 12'h000;
            data_en_q     <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            rgb_q         <= rgb_d;
            data_en_q     <= data_en_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign rgb         = rgb_q;
    assign data_en     = data_en_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Directed bench for vga_timing_ctrl on a reduced raster so full frames stay short;
// a cycle-index reference model feeds a scoreboard of expected registered outputs.
module tb_vga_timing_ctrl;

    localparam int HS = 10, HB = 6, HA = 80, HF = 4;
    localparam int VS = 2,  VB = 3, VA = 20, VF = 2;
    localparam int HT = HS + HB + HA + HF;
    localparam int VT = VS + VB + VA + VF;
    localparam int HA0 = HS + HB;
    localparam int VA0 = VS + VB;

    logic        vga_clk, rst_n, mode_fff;
    logic [23:0] pos_data;
    logic [9:0]  pos_x, pos_y;
    logic        hsync, vsync, data_en, frame_start;
    logic [11:0] rgb;

    vga_timing_ctrl #(
        .H_SYNC(HS), .H_BACK(HB), .H_ACTIVE(HA), .H_FRONT(HF),
        .V_SYNC(VS), .V_BACK(VB), .V_ACTIVE(VA), .V_FRONT(VF), .SYNC_POL(0)
    ) dut (
        .vga_clk(vga_clk), .rst_n(rst_n), .pos_data(pos_data),
        .pos_x(pos_x), .pos_y(pos_y), .hsync(hsync), .vsync(vsync),
        .rgb(rgb), .data_en(data_en), .frame_start(frame_start)
    );

    assign pos_data = mode_fff ? 24'hFFFFFF : {pos_x[7:0], pos_y[7:0], 8'hA5};

    initial vga_clk = 1'b0;
    always #20 vga_clk = ~vga_clk;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        de;
        logic [11:0] rgb;
        logic        fs;
    } exp_t;

    exp_t sb[$];
    int n_chk = 0, n_pass = 0;
    int t = 0, cyc = 0, last_fs = -1;
    int ln_hs = 0, ln_de = 0, fr_vs = 0, fr_de = 0;
    logic de_seen = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // One clock: check the combinational coordinate, queue the expected register
    // contents for the current counter value, then compare after the edge.
    task automatic tick();
        int h, v, f;
        logic act;
        logic [9:0] px, py;
        logic [23:0] pd;
        exp_t e;
        h   = t % HT;
        v   = (t / HT) % VT;
        f   = t / (HT * VT);
        act = (h >= HA0) && (h < HA0 + HA) && (v >= VA0) && (v < VA0 + VA);
        px  = act ? 10'(h - HA0) : 10'd0;
        py  = act ? 10'(v - VA0) : 10'd0;
        chk("pos_x", 32'(pos_x), 32'(px));
        chk("pos_y", 32'(pos_y), 32'(py));
        pd = mode_fff ? 24'hFFFFFF : {px[7:0], py[7:0], 8'hA5};
        e.hs  = !(h < HS);
        e.vs  = !(v < VS);
        e.de  = act;
        e.rgb = act ? {pd[23:20], pd[15:12], pd[7:4]} : 12'h000;
        e.fs  = (h == 0) && (v == 0);
        sb.push_back(e);

        @(posedge vga_clk);
        #1;
        e = sb.pop_front();
        chk("regs", 32'({hsync, vsync, data_en, rgb, frame_start}), 32'(e));

        if (!mode_fff && act && px == 10'd5 && py == 10'd0)
            chk("rgb_px05_py00", 32'(rgb), 32'h00A);
        if (!mode_fff && act && px == 10'h3F && py == 10'h12)
            chk("rgb_px3f_py12", 32'(rgb), 32'h31A);
        if (mode_fff && v >= VA0 && v < VA0 + VA && h == HA0 + HA)
            chk("rgb_hend_blank", 32'({data_en, rgb}), 32'h0);
        if (mode_fff && v >= VA0 && v < VA0 + VA && h == HA0 + HA - 1)
            chk("rgb_hlast_vis", 32'({data_en, rgb}), 32'h1FFF);
        if (mode_fff && v == VA0 + VA && h == HA0 + 10)
            chk("rgb_vend_blank", 32'({data_en, rgb}), 32'h0);

        if (f == 0 && v == VA0) begin
            if (h == 0) de_seen = 1'b0;
            ln_hs += int'(!hsync);
            ln_de += int'(data_en);
            if (data_en && !de_seen) begin
                chk("de_start_h", 32'(h), 32'(HA0));
                de_seen = 1'b1;
            end
            if (h == HT - 1) begin
                chk("line_hsync_low", 32'(ln_hs), 32'(HS));
                chk("line_de_high", 32'(ln_de), 32'(HA));
            end
        end
        if (f < 2) begin
            fr_vs += int'(!vsync);
            fr_de += int'(data_en);
            if (h == HT - 1 && v == VT - 1) begin
                chk("frame_vsync_low", 32'(fr_vs), 32'(VS * HT));
                chk("frame_de_high", 32'(fr_de), 32'(HA * VA));
                fr_vs = 0;
                fr_de = 0;
            end
        end
        if (frame_start) begin
            if (last_fs >= 0) chk("fs_gap", 32'(cyc - last_fs), 32'(HT * VT));
            last_fs = cyc;
        end
        t++;
        cyc++;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_hsync"}, 32'(hsync), 32'h1);
        chk({tag, "_vsync"}, 32'(vsync), 32'h1);
        chk({tag, "_rgb"}, 32'(rgb), 32'h0);
        chk({tag, "_de"}, 32'(data_en), 32'h0);
        chk({tag, "_fs"}, 32'(frame_start), 32'h0);
        chk({tag, "_pos"}, 32'({pos_x, pos_y}), 32'h0);
    endtask

    initial begin
        rst_n    = 1'b0;
        mode_fff = 1'b0;
        repeat (3) @(posedge vga_clk);
        #1;
        chk_reset_outputs("rst_hold");

        @(negedge vga_clk);
        rst_n = 1'b1;
        t = 0;
        tick();
        chk("first_fs", 32'(frame_start), 32'h1);
        chk("first_sync", 32'({hsync, vsync}), 32'h0);
        repeat (HT * VT - 1) tick();

        mode_fff = 1'b1;
        repeat (2 * HT * VT) tick();

        // Park the counters mid-line, mid-frame, then pull reset between edges.
        repeat (10 * HT + 40) tick();
        #5;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("mid_rst");
        repeat (3) @(posedge vga_clk);
        @(negedge vga_clk);
        rst_n   = 1'b1;
        t       = 0;
        last_fs = -1;
        tick();
        chk("rst_fs", 32'(frame_start), 32'h1);
        chk("rst_sync", 32'({hsync, vsync}), 32'h0);
        repeat (3 * HT) tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/vga_timing_ctrl.md
Name: vga_timing_ctrl

Overview:
- Drives the VGA connector for 640x480@60 Hz from the 25 MHz vga_clk.
- Generates the horizontal and vertical counters, hsync and vsync.
- Publishes the current pixel coordinate (pos_x, pos_y) to the mode-specific pixel generators (free mode, play mode, menus). Those generators return pos_data combinationally.
- Samples pos_data and registers the 12-bit RGB output together with the sync signals, so colour and sync stay aligned.

Parameters:
H_SYNC, 96, hsync pulse width in clocks
H_BACK, 48, horizontal back porch in clocks
H_ACTIVE, 640, visible pixels per line
H_FRONT, 16, horizontal front porch in clocks
V_SYNC, 2, vsync pulse width in lines
V_BACK, 33, vertical back porch in lines
V_ACTIVE, 480, visible lines per frame
V_FRONT, 10, vertical front porch in lines
SYNC_POL, 0, sync pulse level (0 = active-low pulse, 1 = active-high pulse)

Ports:
vga_clk  in  1  pixel clock, 25 MHz; all state on rising edge
rst_n  in  1  asynchronous active-low reset
pos_data  in  24  {R[7:0],G[7:0],B[7:0]} for the coordinate currently on pos_x/pos_y (combinational from the pixel generator)
pos_x  out  10  active-area column 0..639; 0 outside active area
pos_y  out  10  active-area row 0..479; 0 outside active area
hsync  out  1  horizontal sync, registered
vsync  out  1  vertical sync, registered
rgb  out  12  {R[7:4],G[7:4],B[7:4]} of the sampled pos_data, registered; 0 when blanking
data_en  out  1  registered; 1 when rgb carries a visible pixel
frame_start  out  1  registered one-clock pulse marking the first clock of each frame

Behaviour:
Derived constants:
- H_TOTAL = sum of the H parameters = 800.
- V_TOTAL = sum of the V parameters = 525.
- Field order in each dimension: sync, back porch, active, front porch.

Counters:
- h_cnt is a 10-bit register counting 0..H_TOTAL-1. It wraps to 0 after H_TOTAL-1.
- v_cnt is a 10-bit register. It increments only on the clock where h_cnt wraps, and wraps to 0 after V_TOTAL-1 at that same clock.
- There are no other increment paths, and no counter value ever exceeds TOTAL-1.

Active window (combinational from the counters):
- h_act = (H_SYNC+H_BACK <= h_cnt < H_SYNC+H_BACK+H_ACTIVE), i.e. h_cnt 144..783.
- v_act = (V_SYNC+V_BACK <= v_cnt < V_SYNC+V_BACK+V_ACTIVE), i.e. v_cnt 35..514.
- act = h_act & v_act.

Coordinates (combinational from registered counters, so no glitch path through logic):
- pos_x = act ? h_cnt-(H_SYNC+H_BACK) : 0.
- pos_y = act ? v_cnt-(V_SYNC+V_BACK) : 0.
- All subtraction is done at 10-bit width.

Output stage (one register stage, latency 1 clock from the counters):
- hsync <= (h_cnt < H_SYNC) ? SYNC_POL : ~SYNC_POL.
- vsync <= (v_cnt < V_SYNC) ? SYNC_POL : ~SYNC_POL.
- data_en <= act.
- rgb <= act ? {pos_data[23:20],pos_data[15:12],pos_data[7:4]} : 12'h000.
- frame_start <= (h_cnt==0 && v_cnt==0).
- Because hsync, vsync, rgb and data_en all share the same single stage, they are mutually aligned.

Reset (rst_n low, asynchronous):
- h_cnt=0, v_cnt=0.
- hsync=~SYNC_POL, vsync=~SYNC_POL (inactive level).
- rgb=0, data_en=0, frame_start=0.
- pos_x=0 and pos_y=0, following from the counter values.

Reset release and mid-frame reset:
- After release, the first rising edge registers the outputs for h_cnt=0, v_cnt=0. That edge sets frame_start=1 and drives hsync and vsync active, so a full frame begins immediately.
- Reset asserted mid-frame aborts the current frame with no partial line preserved. After release the block behaves exactly as after power-up.

Boundary cases:
- Last pixel of a line (h_cnt=783) is visible; h_cnt=784 blanks.
- At h_cnt=799 with v_cnt=524, both counters wrap on the same edge.
- pos_data is ignored whenever act=0.

Test Plan:
- Reset hold, then release -> during reset: rgb=0, data_en=0, hsync=vsync=1 (SYNC_POL=0), pos_x=pos_y=0. First clock after release: frame_start=1, hsync=0, vsync=0.
- Free-run one line on v_cnt=35 -> hsync is low for exactly 96 consecutive clocks out of 800. data_en is high for exactly 640 clocks, starting on the clock after h_cnt=144. pos_x steps 0..639 consecutively.
- Drive pos_data={pos_x[7:0],pos_y[7:0],8'hA5} -> at the clock after pos_x=5, pos_y=0, rgb=12'h00A. At the clock after pos_x=0x3F, pos_y=0x12, rgb=12'h31A.
- Run two full frames -> frame_start pulses are exactly 420000 clocks apart. vsync is low for exactly 1600 clocks per frame. data_en is high for 307200 clocks per frame. No counter value exceeds 799/524.
- pos_data=24'hFFFFFF held constant -> rgb=12'hFFF only while data_en=1. rgb=0 on every porch and sync clock, including h_cnt=784 and v_cnt=515.
- Assert rst_n mid-line at h_cnt=400, v_cnt=200, for 3 clocks -> outputs go to reset values asynchronously (same cycle). After release, timing restarts at h_cnt=0, v_cnt=0 with frame_start=1.
